// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku board datapath: board geometry, hex
// codes for the readout format, the converter state encoding and small
// bit-counting helpers used by the one-hot cell encoder.
package sudoku_pkg;

    localparam int DIM   = 9;
    localparam int CELLS = 81;
    localparam int BIN_W = 9;
    localparam int HEX_W = 4;

    localparam logic [HEX_W-1:0] HEX_EMPTY = 4'h0;
    localparam logic [HEX_W-1:0] HEX_ERR   = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of set bits in a one-hot cell vector (0..9).
    function automatic logic [HEX_W-1:0] count_ones(input logic [BIN_W-1:0] v);
        logic [HEX_W-1:0] cnt;
        cnt = 4'd0;
        for (int k = 0; k < BIN_W; k++) begin
            cnt = cnt + {3'b000, v[k]};
        end
        return cnt;
    endfunction

    // Digit (k+1) of the single set bit k. Only meaningful when exactly one
    // bit is set; with several bits set the codes OR together, which the
    // caller overrides with HEX_ERR anyway.
    function automatic logic [HEX_W-1:0] onehot_digit(input logic [BIN_W-1:0] v);
        logic [HEX_W-1:0] idx;
        idx = 4'd0;
        for (int k = 0; k < BIN_W; k++) begin
            idx = idx | ({HEX_W{v[k]}} & HEX_W'(k + 1));
        end
        return idx;
    endfunction

endpackage

// File: rtl/sudoku_bin2hex_cell.sv
// Combinational encoder for one board cell: 9-bit one-hot candidate vector
// to a hex digit. Empty cells are legal (digit 0); any vector with two or
// more bits set is reported as malformed with digit F.
module sudoku_bin2hex_cell
    import sudoku_pkg::*;
(
    input  logic [BIN_W-1:0] bin_i,
    output logic [HEX_W-1:0] hex_o,
    output logic             err_o
);

    logic [HEX_W-1:0] ones_s;

    // Classify the cell by population count and pick its digit.
    always_comb begin
        hex_o  = HEX_EMPTY;
        err_o  = 1'b0;
        ones_s = count_ones(bin_i);
        if (ones_s == 4'd0) begin
            hex_o = HEX_EMPTY;
            err_o = 1'b0;
        end else if (ones_s == 4'd1) begin
            hex_o = onehot_digit(bin_i);
            err_o = 1'b0;
        end else begin
            hex_o = HEX_ERR;
            err_o = 1'b1;
        end
    end

endmodule

// File: rtl/sudoku_bin2hex_seq.sv
// Time-multiplexed one-hot board to hex board packer. A full board is
// captured on the input handshake, then CELLS_PER_STEP cells are encoded
// per cycle from the captured copy, and the finished hex/err board is held
// on the output until the consumer accepts it.
module sudoku_bin2hex_seq
    import sudoku_pkg::*;
#(
    parameter int CELLS_PER_STEP = 9
)
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bin_valid,
    output logic                     bin_ready,
    input  logic [CELLS*BIN_W-1:0]   bin,
    output logic                     hex_valid,
    input  logic                     hex_ready,
    output logic [CELLS*HEX_W-1:0]   hex,
    output logic [CELLS-1:0]         err,
    output logic                     err_any
);

    localparam int STEPS  = CELLS / CELLS_PER_STEP;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    state_t                   state_q, state_d;
    logic [STEP_W-1:0]        step_q, step_d;
    logic [CELLS*BIN_W-1:0]   cap_q, cap_d;
    logic [CELLS*HEX_W-1:0]   hex_q, hex_d;
    logic [CELLS-1:0]         err_q, err_d;
    logic                     err_any_q, err_any_d;

    logic [BIN_W-1:0]         sel_bin_s [CELLS_PER_STEP];
    logic [HEX_W-1:0]         enc_hex_s [CELLS_PER_STEP];
    logic [CELLS_PER_STEP-1:0] enc_err_s;

    // Slice of the captured board handled this step, one encoder per cell.
    for (genvar g = 0; g < CELLS_PER_STEP; g++) begin : g_enc
        assign sel_bin_s[g] =
            cap_q[(int'(step_q) * CELLS_PER_STEP + g) * BIN_W +: BIN_W];

        sudoku_bin2hex_cell u_cell (
            .bin_i (sel_bin_s[g]),
            .hex_o (enc_hex_s[g]),
            .err_o (enc_err_s[g])
        );
    end

    // Next-state logic: handshake sequencing and per-step result merge.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        cap_d     = cap_q;
        hex_d     = hex_q;
        err_d     = err_q;
        err_any_d = err_any_q;
        case (state_q)
            IDLE: begin
                if (bin_valid) begin
                    cap_d     = bin;
                    hex_d     = '0;
                    err_d     = '0;
                    err_any_d = 1'b0;
                    step_d    = '0;
                    state_d   = CONV;
                end else begin
                    state_d   = IDLE;
                end
            end
            CONV: begin
                for (int j = 0; j < CELLS_PER_STEP; j++) begin
                    hex_d[(int'(step_q) * CELLS_PER_STEP + j) * HEX_W +: HEX_W] = enc_hex_s[j];
                    err_d[int'(step_q) * CELLS_PER_STEP + j] = enc_err_s[j];
                end
                if (step_q == LAST_STEP) begin
                    // err_d already contains this final slice.
                    err_any_d = |err_d;
                    step_d    = '0;
                    state_d   = DONE;
                end else begin
                    step_d    = step_q + STEP_W'(1);
                    state_d   = CONV;
                end
            end
            DONE: begin
                if (hex_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            step_q    <= '0;
            cap_q     <= '0;
            hex_q     <= '0;
            err_q     <= '0;
            err_any_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            cap_q     <= cap_d;
            hex_q     <= hex_d;
            err_q     <= err_d;
            err_any_q <= err_any_d;
        end
    end

    assign bin_ready = (state_q == IDLE);
    assign hex_valid = (state_q == DONE);
    assign hex       = hex_q;
    assign err       = err_q;
    assign err_any   = err_any_q;

endmodule

// File: tb/tb_sudoku_bin2hex_seq.sv
// Bench for the one-hot to hex board packer. Three copies run with 9, 1
// and 81 cells per step; results are compared against a cell-by-cell
// reference model derived from the encoding rules.
module tb_sudoku_bin2hex_seq;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          hex_ready = 1'b0;
    logic [728:0]  bin = '0;
    logic [2:0]    bin_valid_w = 3'b000;
    logic [2:0]    bin_ready_w;
    logic [2:0]    hex_valid_w;
    logic [2:0]    err_any_w;
    logic [323:0]  hex_w [3];
    logic [80:0]   err_w [3];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sudoku_bin2hex_seq #(.CELLS_PER_STEP(9)) dut9 (
        .clk(clk), .rst(rst), .bin_valid(bin_valid_w[0]), .bin_ready(bin_ready_w[0]),
        .bin(bin), .hex_valid(hex_valid_w[0]), .hex_ready(hex_ready),
        .hex(hex_w[0]), .err(err_w[0]), .err_any(err_any_w[0]));

    sudoku_bin2hex_seq #(.CELLS_PER_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .bin_valid(bin_valid_w[1]), .bin_ready(bin_ready_w[1]),
        .bin(bin), .hex_valid(hex_valid_w[1]), .hex_ready(hex_ready),
        .hex(hex_w[1]), .err(err_w[1]), .err_any(err_any_w[1]));

    sudoku_bin2hex_seq #(.CELLS_PER_STEP(81)) dut81 (
        .clk(clk), .rst(rst), .bin_valid(bin_valid_w[2]), .bin_ready(bin_ready_w[2]),
        .bin(bin), .hex_valid(hex_valid_w[2]), .hex_ready(hex_ready),
        .hex(hex_w[2]), .err(err_w[2]), .err_any(err_any_w[2]));

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Reference: empty -> 0, single bit k -> k+1, anything else -> F/err.
    task automatic model(input logic [728:0] b, output logic [323:0] h, output logic [80:0] e);
        logic [8:0] v;
        h = '0;
        e = '0;
        for (int i = 0; i < 81; i++) begin
            v = b[i*9 +: 9];
            if (v == 9'd0) begin
                h[i*4 +: 4] = 4'h0;
            end else begin
                h[i*4 +: 4] = 4'hF;
                e[i] = 1'b1;
                for (int k = 0; k < 9; k++) begin
                    if (v == (9'd1 << k)) begin
                        h[i*4 +: 4] = 4'(k + 1);
                        e[i] = 1'b0;
                    end
                end
            end
        end
    endtask

    function automatic logic [728:0] rand_board();
        logic [728:0] b;
        int r;
        b = '0;
        for (int i = 0; i < 81; i++) begin
            r = int'($urandom_range(0, 13));
            if (r == 0)      b[i*9 +: 9] = 9'd0;
            else if (r < 10) b[i*9 +: 9] = 9'd1 << (r - 1);
            else             b[i*9 +: 9] = 9'($urandom);
        end
        return b;
    endfunction

    function automatic logic [728:0] diag_board();
        logic [728:0] b;
        b = '0;
        for (int i = 0; i < 81; i++) b[i*9 +: 9] = 9'd1 << (i % 9);
        return b;
    endfunction

    // Offer a board, time the result, compare hex/err/err_any. Leaves DONE held.
    task automatic convert(input int inst, input logic [728:0] b, input int exp_lat, input string tag);
        logic [323:0] eh;
        logic [80:0]  ee;
        int n;
        model(b, eh, ee);
        @(negedge clk);
        chk({tag, "_rdy"}, 512'(bin_ready_w[inst]), 512'(1'b1));
        bin = b;
        bin_valid_w[inst] = 1'b1;
        @(negedge clk);
        bin_valid_w[inst] = 1'b0;
        bin = rand_board();
        n = 0;
        while (hex_valid_w[inst] !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_lat"}, 512'(n), 512'(exp_lat));
        chk({tag, "_hex"}, 512'(hex_w[inst]), 512'(eh));
        chk({tag, "_err"}, 512'(err_w[inst]), 512'(ee));
        chk({tag, "_any"}, 512'(err_any_w[inst]), 512'(|ee));
    endtask

    task automatic release_result(input int inst, input string tag);
        @(negedge clk);
        hex_ready = 1'b1;
        @(negedge clk);
        hex_ready = 1'b0;
        chk({tag, "_idle_rdy"}, 512'(bin_ready_w[inst]), 512'(1'b1));
        chk({tag, "_idle_vld"}, 512'(hex_valid_w[inst]), 512'(1'b0));
    endtask

    initial begin
        logic [728:0] b;
        logic [323:0] eh;
        logic [80:0]  ee;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst%0d_rdy", i), 512'(bin_ready_w[i]), 512'(1'b1));
            chk($sformatf("rst%0d_vld", i), 512'(hex_valid_w[i]), 512'(1'b0));
            chk($sformatf("rst%0d_hex", i), 512'(hex_w[i]), 512'(0));
            chk($sformatf("rst%0d_err", i), 512'(err_w[i]), 512'(0));
            chk($sformatf("rst%0d_any", i), 512'(err_any_w[i]), 512'(1'b0));
        end

        // Diagonal one-hot, empty board, malformed cells 40 and 80.
        convert(0, diag_board(), 9, "diag");
        release_result(0, "diag");
        convert(0, '0, 9, "zero");
        release_result(0, "zero");
        b = diag_board();
        b[40*9 +: 9] = 9'b000000101;
        b[80*9 +: 9] = 9'h1FF;
        convert(0, b, 9, "bad");
        chk("bad_h40", 512'(hex_w[0][40*4 +: 4]), 512'(4'hF));
        chk("bad_h80", 512'(hex_w[0][80*4 +: 4]), 512'(4'hF));
        release_result(0, "bad");

        // Same boards at one cell per step and whole board per step.
        convert(1, diag_board(), 81, "c1_diag");
        release_result(1, "c1_diag");
        convert(1, b, 81, "c1_bad");
        release_result(1, "c1_bad");
        convert(2, diag_board(), 1, "c81_diag");
        release_result(2, "c81_diag");
        convert(2, b, 1, "c81_bad");
        release_result(2, "c81_bad");

        // Random boards on every width.
        for (int t = 0; t < 6; t++) begin
            convert(0, rand_board(), 9, $sformatf("rnd%0d", t));
            release_result(0, "rnd");
        end
        convert(1, rand_board(), 81, "c1_rnd");
        release_result(1, "c1_rnd");
        convert(2, rand_board(), 1, "c81_rnd");
        release_result(2, "c81_rnd");

        // Backpressure: result must stay put while the input side churns.
        b = rand_board();
        model(b, eh, ee);
        convert(0, b, 9, "hold");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bin = rand_board();
            bin_valid_w[0] = 1'($urandom);
            chk("hold_hex", 512'(hex_w[0]), 512'(eh));
            chk("hold_err", 512'(err_w[0]), 512'(ee));
            chk("hold_rdy", 512'(bin_ready_w[0]), 512'(1'b0));
            chk("hold_vld", 512'(hex_valid_w[0]), 512'(1'b1));
        end
        bin_valid_w[0] = 1'b0;
        release_result(0, "hold");

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin = diag_board();
        bin_valid_w[0] = 1'b1;
        @(negedge clk);
        bin_valid_w[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rdy", 512'(bin_ready_w[0]), 512'(1'b0));
        chk("mid_vld", 512'(hex_valid_w[0]), 512'(1'b0));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_rdy", 512'(bin_ready_w[0]), 512'(1'b1));
        chk("mrst_vld", 512'(hex_valid_w[0]), 512'(1'b0));
        chk("mrst_hex", 512'(hex_w[0]), 512'(0));
        chk("mrst_err", 512'(err_w[0]), 512'(0));
        convert(0, rand_board(), 9, "after_rst");
        release_result(0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
